// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter: transfer types, response codes,
// per-port FSM states and data-phase owner encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StAddrOut,
    StData
  } port_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnM0,
    OwnM1
  } owner_e;

  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

  // Wide enough for the largest supported starvation threshold (15).
  localparam int unsigned WaitW = 4;

endpackage

// File: rtl/ahblite_arbiter_2m_if.sv
// AHB-Lite signal bundle; the master modport drives the address phase, the slave
// modport returns ready/response/read data.
interface ahblite_arbiter_2m_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output haddr, htrans, hwrite, hsize, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahblite_input_stage.sv
// Per-master input stage: request hold register, port FSM and the stall/response
// signals seen by that master.
module ahblite_input_stage
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              bus_hready,
  input  logic              bus_hresp,
  input  logic              is_owner,
  input  logic              grant,
  output logic              req,
  output logic              cont,
  output logic              held,
  output logic [ADDR_W-1:0] held_haddr,
  output logic [1:0]        held_htrans,
  output logic              held_hwrite,
  output logic [2:0]        held_hsize,
  output logic              hready,
  output logic              hresp
);

  port_state_e       state_q, state_d;
  logic              valid, capture;
  logic [ADDR_W-1:0] haddr_q;
  logic [1:0]        htrans_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;

  assign held   = (state_q == StPend);
  assign hready = held ? 1'b0 : (is_owner ? bus_hready : 1'b1);
  assign hresp  = (is_owner && bus_hresp == RespError) ? RespError : RespOkay;
  assign valid  = !held && hready && htrans[1];
  assign req    = held || valid;
  // SEQ and BUSY from the current owner both continue its burst.
  assign cont   = !held && is_owner && bus_hready &&
                  (htrans == TransSeq || htrans == TransBusy);

  assign held_haddr  = haddr_q;
  assign held_htrans = htrans_q;
  assign held_hwrite = hwrite_q;
  assign held_hsize  = hsize_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      StPend: if (grant) state_d = StAddrOut;
      StIdle, StAddrOut, StData: begin
        if (valid) begin
          state_d = grant ? StData : StPend;
          capture = !grant;
        end else if (state_q == StIdle || bus_hready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      haddr_q  <= '0;
      htrans_q <= TransIdle;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        haddr_q  <= haddr;
        htrans_q <= htrans;
        hwrite_q <= hwrite;
        hsize_q  <= hsize;
      end
    end
  end

endmodule

// File: rtl/ahblite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: fixed M0-over-M1 priority with burst lock and an M1
// starvation guard; routes each data phase back to the master that owns it.
module ahblite_arbiter_2m
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahblite_arbiter_2m_if.slave  m0,
  ahblite_arbiter_2m_if.slave  m1,
  ahblite_arbiter_2m_if.master bus,
  output logic [15:0]          dma_stall_cnt
);

  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  owner_e            owner_q, win;
  logic [WaitW-1:0]  wait_q;
  logic [15:0]       stall_q;
  logic              req0, req1, cont0, cont1, held0, held1;
  logic [ADDR_W-1:0] hold_addr0, hold_addr1, haddr_mux;
  logic [1:0]        hold_trans0, hold_trans1, htrans_mux;
  logic              hold_write0, hold_write1, hwrite_mux;
  logic [2:0]        hold_size0, hold_size1, hsize_mux;
  logic [DATA_W-1:0] hwdata_mux;

  ahblite_input_stage #(.ADDR_W(ADDR_W)) u_in0 (
    .clk(hclk), .rst(hreset),
    .haddr(m0.haddr), .htrans(m0.htrans), .hwrite(m0.hwrite), .hsize(m0.hsize),
    .bus_hready(bus.hready), .bus_hresp(bus.hresp),
    .is_owner(owner_q == OwnM0), .grant(win == OwnM0),
    .req(req0), .cont(cont0), .held(held0),
    .held_haddr(hold_addr0), .held_htrans(hold_trans0), .held_hwrite(hold_write0),
    .held_hsize(hold_size0),
    .hready(m0.hready), .hresp(m0.hresp)
  );

  ahblite_input_stage #(.ADDR_W(ADDR_W)) u_in1 (
    .clk(hclk), .rst(hreset),
    .haddr(m1.haddr), .htrans(m1.htrans), .hwrite(m1.hwrite), .hsize(m1.hsize),
    .bus_hready(bus.hready), .bus_hresp(bus.hresp),
    .is_owner(owner_q == OwnM1), .grant(win == OwnM1),
    .req(req1), .cont(cont1), .held(held1),
    .held_haddr(hold_addr1), .held_htrans(hold_trans1), .held_hwrite(hold_write1),
    .held_hsize(hold_size1),
    .hready(m1.hready), .hresp(m1.hresp)
  );

  always_comb begin
    win = OwnNone;
    if (!hreset && bus.hready) begin
      if (cont0)                          win = OwnM0;
      else if (cont1)                     win = OwnM1;
      else if (req1 && wait_q == MaxWait) win = OwnM1;
      else if (req0)                      win = OwnM0;
      else if (req1)                      win = OwnM1;
    end
  end

  // Idle bus parks on M0 with HTRANS=IDLE; direct grants pass through combinationally.
  always_comb begin
    haddr_mux  = m0.haddr;
    htrans_mux = TransIdle;
    hwrite_mux = m0.hwrite;
    hsize_mux  = m0.hsize;
    case (win)
      OwnM0: begin
        haddr_mux  = held0 ? hold_addr0  : m0.haddr;
        htrans_mux = held0 ? hold_trans0 : m0.htrans;
        hwrite_mux = held0 ? hold_write0 : m0.hwrite;
        hsize_mux  = held0 ? hold_size0  : m0.hsize;
      end
      OwnM1: begin
        haddr_mux  = held1 ? hold_addr1  : m1.haddr;
        htrans_mux = held1 ? hold_trans1 : m1.htrans;
        hwrite_mux = held1 ? hold_write1 : m1.hwrite;
        hsize_mux  = held1 ? hold_size1  : m1.hsize;
      end
      default: ;
    endcase
    if (hreset) begin
      haddr_mux  = '0;
      htrans_mux = TransIdle;
      hwrite_mux = 1'b0;
      hsize_mux  = '0;
    end
  end

  assign hwdata_mux    = (owner_q == OwnM1) ? m1.hwdata : m0.hwdata;
  assign bus.haddr     = haddr_mux;
  assign bus.htrans    = htrans_mux;
  assign bus.hwrite    = hwrite_mux;
  assign bus.hsize     = hsize_mux;
  assign bus.hwdata    = hwdata_mux;
  assign m0.hrdata     = bus.hrdata;
  assign m1.hrdata     = bus.hrdata;
  assign dma_stall_cnt = stall_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      owner_q <= OwnNone;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      if (bus.hready) owner_q <= win;
      if (win == OwnM1)                     wait_q <= '0;
      else if (held1 && wait_q != MaxWait)  wait_q <= wait_q + 1'b1;
      if (held1 && win != OwnM1 && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

endmodule
